// File: rtl/sobel_pkg.sv
// Shared types and defaults for the sobel output path.
package sobel_pkg;

  typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} tx_state_t;

  localparam int PIXEL_W             = 8;
  localparam int DEFAULT_DEPTH       = 64;
  localparam int DEFAULT_ACK_TIMEOUT = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, registered write-ready and live occupancy.
module sync_fifo
  import sobel_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = PIXEL_W,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              ready,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0] PTR_ONE = 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic              push, pop, full_next;

  assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[ADDR_W-1:0]];
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;

  always_comb begin
    wr_ptr_next = push ? wr_ptr + PTR_ONE : wr_ptr;
    rd_ptr_next = pop  ? rd_ptr + PTR_ONE : rd_ptr;
    full_next   = (wr_ptr_next[ADDR_W] != rd_ptr_next[ADDR_W]) &&
                  (wr_ptr_next[ADDR_W-1:0] == rd_ptr_next[ADDR_W-1:0]);
  end

  // ready is the registered image of the post-edge occupancy, so it equals !full
  // every cycle after reset and is held low while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ready  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      ready  <= !full_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

endmodule

// File: rtl/sobel_tx_buffer.sv
// Buffers filtered pixel bytes and hands them to uart_tx one frame at a time.
module sobel_tx_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int DATA_W      = PIXEL_W,
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     valid_in,
  output logic                     ready_in,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         sent_count,
  output logic                     timeout_err
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  tx_state_t         state, state_next;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_full, fifo_empty, pop;
  logic              cnt_clr, cnt_inc, sent_inc, err_set;
  logic [TO_W-1:0]   to_cnt;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (valid_in && ready_in && !fifo_full),
    .wr_data (data_in),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .ready   (ready_in),
    .level   (fifo_level)
  );

  assign tx_start = (state == START);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    sent_inc   = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !tx_busy) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        cnt_clr    = 1'b1;
        state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          sent_inc   = 1'b1;
          state_next = WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          // No acknowledge: count the byte as sent so the stream keeps moving.
          err_set    = 1'b1;
          sent_inc   = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_data     <= '0;
      to_cnt      <= '0;
      sent_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_next;
      if (pop) tx_data <= fifo_data;
      if (cnt_clr)      to_cnt <= '0;
      else if (cnt_inc) to_cnt <= to_cnt + TO_W'(1);
      if (sent_inc) sent_count <= sent_count + CNT_W'(1);
      if (err_set)  timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sobel_tx_buffer.sv
// Scoreboard bench for sobel_tx_buffer with a behavioural uart_tx busy model.
module tb_sobel_tx_buffer;

  localparam int DEPTH       = 64;
  localparam int DATA_W      = 8;
  localparam int ACK_TIMEOUT = 16;
  localparam int CNT_W       = 16;
  localparam int LVL_W       = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              valid_in = 1'b0;
  logic              ready_in;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_busy = 1'b0;
  logic [LVL_W-1:0]  fifo_level;
  logic [CNT_W-1:0]  sent_count;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int max_level = 0;
  int exp_sent = 0;
  logic [DATA_W-1:0] exp_q[$];

  bit model_en = 1'b0;
  int busy_cycles = 40;

  always #5 clk = ~clk;

  sobel_tx_buffer #(
    .DEPTH       (DEPTH),
    .DATA_W      (DATA_W),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .ready_in    (ready_in),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .fifo_level  (fifo_level),
    .sent_count  (sent_count),
    .timeout_err (timeout_err)
  );

  // uart_tx model: busy rises one cycle after tx_start and stays high busy_cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (model_en && rst_n && tx_start) begin
        @(posedge clk); #1;
        tx_busy = 1'b1;
        repeat (busy_cycles) @(posedge clk);
        #1;
        tx_busy = 1'b0;
      end
    end
  end

  // Output side of the scoreboard: each tx_start must carry the oldest pushed byte.
  always @(negedge clk) begin
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    if (rst_n && tx_start) begin
      starts++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tx_start: tx_data=%02h with no byte queued", tx_data);
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          errors++;
          $display("FAIL tx_order: got %02h expected %02h", tx_data, e);
        end
      end
    end
  end

  task automatic push_byte(input logic [DATA_W-1:0] b);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    data_in  = b;
    valid_in = 1'b1;
    while (!acc && n < 5000) begin
      acc = ready_in;
      @(posedge clk); #1;
      n++;
    end
    if (acc) begin
      exp_q.push_back(b);
    end else begin
      checks++;
      errors++;
      $display("FAIL push_accept: byte %02h never accepted", b);
    end
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !tx_busy && fifo_level == '0) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= bound) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d bytes still pending, level %0d", exp_q.size(), fifo_level);
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid_in = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      checks++;
      if (ready_in !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready_low: got %b expected 0", ready_in);
      end
    end
    checks++;
    if (fifo_level !== '0 || tx_start !== 1'b0 || sent_count !== '0 ||
        timeout_err !== 1'b0 || tx_data !== '0) begin
      errors++;
      $display("FAIL reset_values: level=%0d start=%b sent=%0d err=%b data=%02h expected all 0",
               fifo_level, tx_start, sent_count, timeout_err, tx_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready_in !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise: got %b expected 1", ready_in);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (fifo_level !== '0 || starts != 0) begin
      errors++;
      $display("FAIL reset_idle: level=%0d starts=%0d expected 0/0", fifo_level, starts);
    end
  endtask

  task automatic test_single_byte();
    int s0;
    s0 = starts;
    model_en = 1'b1;
    busy_cycles = 40;
    push_byte(8'hA5);
    valid_in = 1'b0;
    wait_drain(500);
    exp_sent += 1;
    checks++;
    if (starts - s0 != 1) begin
      errors++;
      $display("FAIL single_starts: got %0d expected 1", starts - s0);
    end
    checks++;
    if (tx_data !== 8'hA5 || sent_count !== CNT_W'(exp_sent) || fifo_level !== '0 ||
        timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL single_state: data=%02h sent=%0d level=%0d err=%b expected a5/%0d/0/0",
               tx_data, sent_count, fifo_level, timeout_err, exp_sent);
    end
  endtask

  task automatic test_burst_fill();
    int s0, accepted, drop_at, n;
    logic acc;
    s0 = starts;
    accepted = 0;
    drop_at = -1;
    busy_cycles = 100;
    for (int i = 0; i < 70; i++) begin
      data_in  = DATA_W'(i);
      valid_in = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 5000) begin
        acc = ready_in;
        if (!ready_in && drop_at < 0) drop_at = accepted;
        @(posedge clk); #1;
        n++;
      end
      if (acc) begin
        accepted++;
        exp_q.push_back(DATA_W'(i));
      end
    end
    valid_in = 1'b0;
    checks++;
    if (drop_at != 64 && drop_at != 65) begin
      errors++;
      $display("FAIL burst_backpressure: ready_in dropped after %0d expected 64 or 65", drop_at);
    end
    wait_drain(12000);
    exp_sent += 70;
    checks++;
    if (starts - s0 != 70 || accepted != 70) begin
      errors++;
      $display("FAIL burst_count: sent %0d accepted %0d expected 70/70", starts - s0, accepted);
    end
    checks++;
    if (sent_count !== CNT_W'(exp_sent)) begin
      errors++;
      $display("FAIL burst_sent_count: got %0d expected %0d", sent_count, exp_sent);
    end
  endtask

  task automatic test_wrap_around();
    int s0;
    s0 = starts;
    max_level = 0;
    busy_cycles = 30;
    for (int i = 0; i < 200; i++) begin
      push_byte(DATA_W'($urandom_range(0, 255)));
      valid_in = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_drain(20000);
    exp_sent += 200;
    checks++;
    if (starts - s0 != 200) begin
      errors++;
      $display("FAIL wrap_count: got %0d expected 200", starts - s0);
    end
    checks++;
    if (max_level != DEPTH) begin
      errors++;
      $display("FAIL wrap_max_level: got %0d expected %0d", max_level, DEPTH);
    end
    checks++;
    if (sent_count !== CNT_W'(exp_sent)) begin
      errors++;
      $display("FAIL wrap_sent_count: got %0d expected %0d", sent_count, exp_sent);
    end
  endtask

  task automatic test_timeout();
    int n;
    model_en = 1'b0;
    tx_busy  = 1'b0;
    push_byte(8'h3C);
    valid_in = 1'b0;
    n = 0;
    while (tx_start !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_start !== 1'b1) begin
      errors++;
      $display("FAIL timeout_start: tx_start=%b expected 1", tx_start);
    end
    repeat (16) @(posedge clk);
    #1;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: timeout_err=%b expected 0 after 16 edges", timeout_err);
    end
    @(posedge clk); #1;
    exp_sent += 1;
    checks++;
    if (timeout_err !== 1'b1 || sent_count !== CNT_W'(exp_sent)) begin
      errors++;
      $display("FAIL timeout_expiry: err=%b sent=%0d expected 1/%0d",
               timeout_err, sent_count, exp_sent);
    end
    push_byte(8'h5A);
    valid_in = 1'b0;
    n = 0;
    while (tx_start !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_start !== 1'b1) begin
      errors++;
      $display("FAIL timeout_second_start: tx_start=%b expected 1", tx_start);
    end
    repeat (25) @(posedge clk);
    #1;
    exp_sent += 1;
    checks++;
    if (sent_count !== CNT_W'(exp_sent) || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_second_sent: sent=%0d err=%b expected %0d/1",
               sent_count, timeout_err, exp_sent);
    end
  endtask

  task automatic test_mid_reset();
    int n, s0;
    model_en = 1'b1;
    busy_cycles = 100;
    for (int i = 0; i < 20; i++) push_byte(DATA_W'(8'h80 + i));
    valid_in = 1'b0;
    n = 0;
    while (tx_busy !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    exp_sent = 0;
    #2;
    checks++;
    if (fifo_level !== '0 || tx_start !== 1'b0 || sent_count !== '0) begin
      errors++;
      $display("FAIL midreset_values: level=%0d start=%b sent=%0d expected 0/0/0",
               fifo_level, tx_start, sent_count);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    s0 = starts;
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (starts != s0 || fifo_level !== '0 || sent_count !== '0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_residual: starts=%0d level=%0d sent=%0d err=%b expected 0/0/0/0",
               starts - s0, fifo_level, sent_count, timeout_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst_fill();
    test_wrap_around();
    test_timeout();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
